// File: rtl/mux_r1.sv
// mux_r1: registered, handshaked N:1 channel selector.
// Picks one of DEPTH packed channels, either by an explicit index or by
// round-robin over the valid channels. The winner goes into a single
// valid/ready output register.
module mux_r1 #(
    parameter int BIT_WIDTH = 4,
    parameter int DEPTH     = 4,
    parameter int SEL_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_n,
    input  logic                       mode,
    input  logic [BIT_WIDTH*DEPTH-1:0] dataIn,
    input  logic [DEPTH-1:0]           validIn,
    output logic [DEPTH-1:0]           readyIn,
    input  logic [SEL_WIDTH-1:0]       sel,
    output logic [BIT_WIDTH-1:0]       dataOut,
    output logic                       validOut,
    input  logic                       readyOut,
    output logic [SEL_WIDTH-1:0]       selOut
);

    logic [SEL_WIDTH-1:0] ptr;
    logic [SEL_WIDTH-1:0] choice;
    logic                 choice_valid;
    logic [BIT_WIDTH-1:0] choice_data;
    logic [SEL_WIDTH-1:0] next_ptr;
    logic                 load;

    logic [SEL_WIDTH-1:0] hi_idx;
    logic                 hi_found;
    logic [SEL_WIDTH-1:0] lo_idx;
    logic                 lo_found;

    // The output register can take a new word when enabled and it is empty or being drained.
    assign load = !en_n && (!validOut || readyOut);

    // Round-robin search: lowest valid index at or above ptr, else lowest valid index overall.
    always_comb begin
        hi_idx   = '0;
        hi_found = 1'b0;
        lo_idx   = '0;
        lo_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (validIn[i]) begin
                lo_idx   = SEL_WIDTH'(i);
                lo_found = 1'b1;
                if (SEL_WIDTH'(i) >= ptr) begin
                    hi_idx   = SEL_WIDTH'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    // Channel choice: explicit index in mode 0 (out-of-range index is never valid), arbiter in mode 1.
    always_comb begin
        choice       = '0;
        choice_valid = 1'b0;
        if (!mode) begin
            choice = sel;
            if (int'(sel) < DEPTH) begin
                choice_valid = validIn[sel];
            end
        end else begin
            choice       = hi_found ? hi_idx : lo_idx;
            choice_valid = lo_found;
        end
    end

    // Data mux and one-hot accept; the loop keeps an out-of-range choice from ever reading past the bus.
    always_comb begin
        choice_data = '0;
        readyIn     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (choice == SEL_WIDTH'(i)) begin
                choice_data = dataIn[BIT_WIDTH*i +: BIT_WIDTH];
                readyIn[i]  = load && choice_valid;
            end
        end
    end

    // Pointer moves to just past the granted channel, wrapping at DEPTH (which need not be a power of 2).
    always_comb begin
        next_ptr = '0;
        if (int'(choice) != DEPTH - 1) begin
            next_ptr = choice + SEL_WIDTH'(1);
        end
    end

    // Output stage and arbitration pointer; a load with no valid choice only empties the stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataOut  <= '0;
            validOut <= 1'b0;
            selOut   <= '0;
            ptr      <= '0;
        end else if (load) begin
            if (choice_valid) begin
                dataOut  <= choice_data;
                selOut   <= choice;
                validOut <= 1'b1;
                if (mode) begin
                    ptr <= next_ptr;
                end
            end else begin
                validOut <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_r1.sv
// tb_mux_r1: directed, table-driven bench for mux_r1 (DEPTH=4) plus a DEPTH=3 instance.
module tb_mux_r1;

    logic        clk;
    logic        rst;
    logic        en_n;
    logic        mode;
    logic [15:0] data_in;
    logic [3:0]  valid_in;
    logic [3:0]  ready_in;
    logic [1:0]  sel;
    logic [3:0]  data_out;
    logic        valid_out;
    logic        ready_out;
    logic [1:0]  sel_out;

    logic        d3_en_n;
    logic        d3_mode;
    logic [11:0] d3_data_in;
    logic [2:0]  d3_valid_in;
    logic [2:0]  d3_ready_in;
    logic [1:0]  d3_sel;
    logic [3:0]  d3_data_out;
    logic        d3_valid_out;
    logic        d3_ready_out;
    logic [1:0]  d3_sel_out;

    int total;
    int bad;

    typedef struct {
        logic        mode;
        logic        en_n;
        logic [15:0] data;
        logic [3:0]  valid;
        logic [1:0]  sel;
        logic        ready_out;
        logic [3:0]  exp_ready_in;
        logic [3:0]  exp_data;
        logic        exp_valid;
        logic [1:0]  exp_sel;
    } vec_t;

    localparam int NUM_VECS = 27;
    vec_t vecs [NUM_VECS];

    mux_r1 #(.BIT_WIDTH(4), .DEPTH(4), .SEL_WIDTH(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en_n     (en_n),
        .mode     (mode),
        .dataIn   (data_in),
        .validIn  (valid_in),
        .readyIn  (ready_in),
        .sel      (sel),
        .dataOut  (data_out),
        .validOut (valid_out),
        .readyOut (ready_out),
        .selOut   (sel_out)
    );

    mux_r1 #(.BIT_WIDTH(4), .DEPTH(3), .SEL_WIDTH(2)) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .en_n     (d3_en_n),
        .mode     (d3_mode),
        .dataIn   (d3_data_in),
        .validIn  (d3_valid_in),
        .readyIn  (d3_ready_in),
        .sel      (d3_sel),
        .dataOut  (d3_data_out),
        .validOut (d3_valid_out),
        .readyOut (d3_ready_out),
        .selOut   (d3_sel_out)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one vector, check the combinational accept, then check the registered result after the edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        mode      = v.mode;
        en_n      = v.en_n;
        data_in   = v.data;
        valid_in  = v.valid;
        sel       = v.sel;
        ready_out = v.ready_out;
        #1;
        checkOutput($sformatf("v%0d readyIn", idx), 32'(ready_in), 32'(v.exp_ready_in));
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d dataOut", idx), 32'(data_out), 32'(v.exp_data));
        checkOutput($sformatf("v%0d validOut", idx), 32'(valid_out), 32'(v.exp_valid));
        checkOutput($sformatf("v%0d selOut", idx), 32'(sel_out), 32'(v.exp_sel));
    endtask

    initial begin
        logic [0:19] ready_pat;
        int          prod_word;
        int          recv;
        logic        fire_in;
        logic        fire_out;
        logic [3:0]  got;

        total = 0;
        bad   = 0;

        //               mode en_n data      valid    sel ro  | rdyIn    dOut  vOut  sOut
        vecs[0]  = '{1'b0, 1'b0, 16'hDCBA, 4'b1111, 2'd2, 1'b1, 4'b0100, 4'hC, 1'b1, 2'd2};
        vecs[1]  = '{1'b0, 1'b0, 16'hDCBA, 4'b1011, 2'd2, 1'b1, 4'b0000, 4'hC, 1'b0, 2'd2};
        vecs[2]  = '{1'b0, 1'b0, 16'hDCBA, 4'b1111, 2'd1, 1'b0, 4'b0010, 4'hB, 1'b1, 2'd1};
        vecs[3]  = '{1'b0, 1'b0, 16'hDCBA, 4'b1111, 2'd0, 1'b0, 4'b0000, 4'hB, 1'b1, 2'd1};
        vecs[4]  = '{1'b0, 1'b1, 16'hDCBA, 4'b1111, 2'd0, 1'b1, 4'b0000, 4'hB, 1'b1, 2'd1};
        vecs[5]  = '{1'b1, 1'b0, 16'hDCBA, 4'b1111, 2'd0, 1'b1, 4'b0001, 4'hA, 1'b1, 2'd0};
        vecs[6]  = '{1'b1, 1'b0, 16'hDCBA, 4'b1111, 2'd0, 1'b1, 4'b0010, 4'hB, 1'b1, 2'd1};
        vecs[7]  = '{1'b1, 1'b0, 16'hDCBA, 4'b1111, 2'd0, 1'b1, 4'b0100, 4'hC, 1'b1, 2'd2};
        vecs[8]  = '{1'b1, 1'b0, 16'hDCBA, 4'b1111, 2'd0, 1'b1, 4'b1000, 4'hD, 1'b1, 2'd3};
        vecs[9]  = '{1'b1, 1'b0, 16'hDCBA, 4'b1111, 2'd0, 1'b1, 4'b0001, 4'hA, 1'b1, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 16'hDCBA, 4'b1111, 2'd0, 1'b1, 4'b0010, 4'hB, 1'b1, 2'd1};
        vecs[11] = '{1'b1, 1'b0, 16'hDCBA, 4'b1010, 2'd0, 1'b1, 4'b1000, 4'hD, 1'b1, 2'd3};
        vecs[12] = '{1'b1, 1'b0, 16'hDCBA, 4'b1010, 2'd0, 1'b1, 4'b0010, 4'hB, 1'b1, 2'd1};
        vecs[13] = '{1'b1, 1'b0, 16'hDCBA, 4'b1010, 2'd0, 1'b1, 4'b1000, 4'hD, 1'b1, 2'd3};
        vecs[14] = '{1'b1, 1'b0, 16'hDCBA, 4'b1010, 2'd0, 1'b1, 4'b0010, 4'hB, 1'b1, 2'd1};
        vecs[15] = '{1'b1, 1'b0, 16'hDCBA, 4'b0100, 2'd0, 1'b1, 4'b0100, 4'hC, 1'b1, 2'd2};
        vecs[16] = '{1'b1, 1'b0, 16'hDCBA, 4'b1001, 2'd0, 1'b1, 4'b1000, 4'hD, 1'b1, 2'd3};
        vecs[17] = '{1'b1, 1'b0, 16'hDCBA, 4'b1001, 2'd0, 1'b1, 4'b0001, 4'hA, 1'b1, 2'd0};
        vecs[18] = '{1'b1, 1'b0, 16'hDCBA, 4'b0000, 2'd0, 1'b1, 4'b0000, 4'hA, 1'b0, 2'd0};
        vecs[19] = '{1'b1, 1'b0, 16'hDCBA, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'hA, 1'b0, 2'd0};
        vecs[20] = '{1'b0, 1'b0, 16'hDCBA, 4'b1111, 2'd3, 1'b1, 4'b1000, 4'hD, 1'b1, 2'd3};
        vecs[21] = '{1'b1, 1'b0, 16'hDCBA, 4'b1111, 2'd0, 1'b1, 4'b0010, 4'hB, 1'b1, 2'd1};
        vecs[22] = '{1'b0, 1'b0, 16'h0005, 4'b0001, 2'd0, 1'b1, 4'b0001, 4'h5, 1'b1, 2'd0};
        vecs[23] = '{1'b0, 1'b0, 16'h0006, 4'b0001, 2'd0, 1'b0, 4'b0000, 4'h5, 1'b1, 2'd0};
        vecs[24] = '{1'b0, 1'b0, 16'h0006, 4'b0001, 2'd0, 1'b0, 4'b0000, 4'h5, 1'b1, 2'd0};
        vecs[25] = '{1'b0, 1'b0, 16'h0006, 4'b0001, 2'd0, 1'b0, 4'b0000, 4'h5, 1'b1, 2'd0};
        vecs[26] = '{1'b0, 1'b0, 16'h0006, 4'b0001, 2'd0, 1'b1, 4'b0001, 4'h6, 1'b1, 2'd0};

        rst          = 1'b0;
        en_n         = 1'b0;
        mode         = 1'b0;
        data_in      = '0;
        valid_in     = '0;
        sel          = '0;
        ready_out    = 1'b0;
        d3_en_n      = 1'b0;
        d3_mode      = 1'b0;
        d3_data_in   = '0;
        d3_valid_in  = '0;
        d3_sel       = '0;
        d3_ready_out = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset dataOut", 32'(data_out), 32'h0);
        checkOutput("reset validOut", 32'(valid_out), 32'h0);
        checkOutput("reset selOut", 32'(sel_out), 32'h0);
        checkOutput("reset d3 validOut", 32'(d3_valid_out), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Drain the held word so the scoreboard starts from an empty stage.
        valid_in  = 4'b0000;
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("drain validOut", 32'(valid_out), 32'h0);

        // Scoreboard: words 1..6 on channel 0 under a ragged consumer must arrive once each, in order.
        ready_pat = 20'b1000_1101_1100_1011_1111;
        prod_word = 1;
        recv      = 0;
        mode      = 1'b0;
        sel       = 2'd0;
        for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
            valid_in  = (prod_word <= 6) ? 4'b0001 : 4'b0000;
            data_in   = 16'(prod_word);
            ready_out = ready_pat[cyc % 20];
            @(negedge clk);
            fire_in  = ready_in[0];
            fire_out = valid_out && ready_out;
            got      = data_out;
            @(posedge clk);
            #1;
            if (fire_out) begin
                checkOutput($sformatf("sb word%0d", recv + 1), 32'(got), 32'(recv + 1));
                recv++;
            end
            if (fire_in) begin
                prod_word++;
            end
        end
        checkOutput("sb count", 32'(recv), 32'd6);

        // Mid-stream reset: load a word, stall it, then pull reset in the middle of the cycle.
        mode      = 1'b0;
        sel       = 2'd3;
        valid_in  = 4'b1111;
        data_in   = 16'hDCBA;
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("pre-reset validOut", 32'(valid_out), 32'h1);
        ready_out = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset dataOut", 32'(data_out), 32'h0);
        checkOutput("async reset validOut", 32'(valid_out), 32'h0);
        checkOutput("async reset selOut", 32'(sel_out), 32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        mode      = 1'b1;
        ready_out = 1'b1;
        #1;
        checkOutput("post-reset readyIn", 32'(ready_in), 32'b0001);
        @(posedge clk);
        #1;
        checkOutput("post-reset selOut", 32'(sel_out), 32'h0);
        checkOutput("post-reset dataOut", 32'(data_out), 32'hA);

        // DEPTH=3 instance: valid in-range select, then sel=3 is treated as no channel.
        d3_mode      = 1'b0;
        d3_sel       = 2'd2;
        d3_valid_in  = 3'b111;
        d3_data_in   = 12'hCBA;
        d3_ready_out = 1'b1;
        #1;
        checkOutput("d3 sel2 readyIn", 32'(d3_ready_in), 32'b100);
        @(posedge clk);
        #1;
        checkOutput("d3 sel2 dataOut", 32'(d3_data_out), 32'hC);
        checkOutput("d3 sel2 validOut", 32'(d3_valid_out), 32'h1);
        checkOutput("d3 sel2 selOut", 32'(d3_sel_out), 32'h2);
        d3_sel = 2'd3;
        #1;
        checkOutput("d3 sel3 readyIn", 32'(d3_ready_in), 32'b000);
        @(posedge clk);
        #1;
        checkOutput("d3 sel3 validOut", 32'(d3_valid_out), 32'h0);
        checkOutput("d3 sel3 dataOut", 32'(d3_data_out), 32'hC);
        d3_mode     = 1'b1;
        d3_valid_in = 3'b110;
        #1;
        checkOutput("d3 rr readyIn", 32'(d3_ready_in), 32'b010);
        @(posedge clk);
        #1;
        checkOutput("d3 rr selOut", 32'(d3_sel_out), 32'h1);
        d3_valid_in = 3'b101;
        #1;
        checkOutput("d3 rr wrap readyIn", 32'(d3_ready_in), 32'b100);
        @(posedge clk);
        #1;
        checkOutput("d3 rr wrap selOut", 32'(d3_sel_out), 32'h2);
        #1;
        checkOutput("d3 rr after wrap readyIn", 32'(d3_ready_in), 32'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
